bit_player: RTL and testbench

//  Transmit-side counterpart of the bit plotter sampler. A host loads a bit sequence into a 2^ADDR_WIDTH x 1 buffer.
//  On start, the block replays the bits serially on bitOut at one bit per 2^PRESCALE_WIDTH clocks, once or looped.
//  It drives test patterns into bitIn-style sampler inputs and into external pins.

---
 rtl/bit_player.sv | 186 ++++++++++++++++++
 tb/tb_bit_player.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_player.sv
// Serial bit-sequence player: host loads a 1-bit-wide buffer, then the
// block replays it on bitOut at one bit per 2^PRESCALE_WIDTH clocks.
module bit_player #(
    parameter int   ADDR_WIDTH     = 14,
    parameter int   PRESCALE_WIDTH = 15,
    parameter logic IDLE_LEVEL     = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  loadValid,
    input  logic                  loadBit,
    output logic                  loadReady,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    output logic [ADDR_WIDTH:0]   fillCount,
    output logic                  bitOut,
    output logic                  bitStrobe,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        S_IDLE,
        S_PLAY
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic mem [DEPTH];
    logic rd_data;
    logic rd_en;
    logic wr_en;

    state_t                    state, state_n;
    logic [ADDR_WIDTH:0]       fill, fill_n;
    logic [ADDR_WIDTH-1:0]     rd_idx, rd_idx_n;
    logic [ADDR_WIDTH-1:0]     last_idx, last_idx_n;
    logic                      loop_mode, loop_mode_n;
    logic                      last_issued, last_issued_n;
    logic [PRESCALE_WIDTH-1:0] pcnt, pcnt_n;
    logic                      v1, v1_n, v2, v2_n;
    logic                      e1, e1_n, e2, e2_n;
    logic                      d2, d2_n;
    logic                      bit_q, bit_n;
    logic                      strobe_q, strobe_n;
    logic                      done_q, done_n;

    logic                      load_fire;
    logic [ADDR_WIDTH:0]       fill_post;
    logic                      tick;

    assign loadReady = (state == S_IDLE) && (fill != FULL);
    assign load_fire = loadReady && loadValid && !clear;
    assign fill_post = clear ? '0
                     : fill + (ADDR_WIDTH+1)'(load_fire);
    assign tick      = (state == S_PLAY) && (pcnt == '0);

    assign fillCount = fill;
    assign bitOut    = bit_q;
    assign bitStrobe = strobe_q;
    assign busy      = (state == S_PLAY);
    assign done      = done_q;

    // Buffer: write port addressed by fill, registered read port.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[fill[ADDR_WIDTH-1:0]] <= loadBit;
        if (rd_en)
            rd_data <= mem[rd_idx];
    end

    always_comb begin
        state_n       = state;
        fill_n        = fill;
        rd_idx_n      = rd_idx;
        last_idx_n    = last_idx;
        loop_mode_n   = loop_mode;
        last_issued_n = last_issued;
        pcnt_n        = pcnt;
        v1_n          = 1'b0;
        e1_n          = 1'b0;
        v2_n          = v1;
        e2_n          = e1;
        d2_n          = rd_data;
        bit_n         = bit_q;
        strobe_n      = 1'b0;
        done_n        = 1'b0;
        wr_en         = 1'b0;
        rd_en         = 1'b0;

        unique case (state)
            S_IDLE: begin
                fill_n = fill_post;
                wr_en  = load_fire;
                bit_n  = IDLE_LEVEL;
                if (start && !stop && fill_post != '0) begin
                    state_n       = S_PLAY;
                    rd_idx_n      = '0;
                    pcnt_n        = '0;
                    loop_mode_n   = loop;
                    last_issued_n = 1'b0;
                    last_idx_n    = fill_post[ADDR_WIDTH-1:0]
                                  - ADDR_WIDTH'(1);
                end
            end
            S_PLAY: begin
                pcnt_n = pcnt + PRESCALE_WIDTH'(1);
                if (stop) begin
                    state_n = S_IDLE;
                    v2_n    = 1'b0;
                    e2_n    = 1'b0;
                    bit_n   = IDLE_LEVEL;
                end else begin
                    if (tick) begin
                        if (last_issued) begin
                            e1_n = 1'b1;
                        end else begin
                            v1_n  = 1'b1;
                            rd_en = 1'b1;
                            if (rd_idx == last_idx) begin
                                if (loop_mode)
                                    rd_idx_n = '0;
                                else
                                    last_issued_n = 1'b1;
                            end else begin
                                rd_idx_n = rd_idx + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    if (v2) begin
                        bit_n    = d2;
                        strobe_n = 1'b1;
                    end
                    // End token shares the read pipeline so the last
                    // bit stays on the line for a whole period.
                    if (e2) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                        bit_n   = IDLE_LEVEL;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            fill        <= '0;
            rd_idx      <= '0;
            last_idx    <= '0;
            loop_mode   <= 1'b0;
            last_issued <= 1'b0;
            pcnt        <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            e1          <= 1'b0;
            e2          <= 1'b0;
            d2          <= 1'b0;
            bit_q       <= IDLE_LEVEL;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            fill        <= fill_n;
            rd_idx      <= rd_idx_n;
            last_idx    <= last_idx_n;
            loop_mode   <= loop_mode_n;
            last_issued <= last_issued_n;
            pcnt        <= pcnt_n;
            v1          <= v1_n;
            v2          <= v2_n;
            e1          <= e1_n;
            e2          <= e2_n;
            d2          <= d2_n;
            bit_q       <= bit_n;
            strobe_q    <= strobe_n;
            done_q      <= done_n;
        end
    end

endmodule

// File: tb/tb_bit_player.sv
// Directed bench for bit_player (ADDR_WIDTH=4, PRESCALE_WIDTH=2).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bit_player;

    logic       clk = 1'b0;
    logic       reset, clear, loadValid, loadBit;
    logic       start, stop, loop;
    logic       loadReady, bitOut, bitStrobe, busy, done;
    logic [4:0] fillCount;

    int nvec = 0;
    int nerr = 0;

    bit_player #(
        .ADDR_WIDTH    (4),
        .PRESCALE_WIDTH(2),
        .IDLE_LEVEL    (1'b0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .loadValid(loadValid),
        .loadBit  (loadBit),
        .loadReady(loadReady),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .fillCount(fillCount),
        .bitOut   (bitOut),
        .bitStrobe(bitStrobe),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic b);
        loadValid = 1'b1;
        loadBit   = b;
        tick();
        loadValid = 1'b0;
    endtask

    // Expects n strobes; the first after 'first' cycles, then every 4.
    task automatic play_bits(input logic [15:0] bits, input int n,
                             input int first, input string tag);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = (i == 0) ? first : 4;
            for (int k = 1; k < gap; k++) begin
                tick();
                check({tag, "_gap_strobe"}, bitStrobe, 0);
                check({tag, "_gap_done"}, done, 0);
            end
            tick();
            check({tag, "_strobe"}, bitStrobe, 1);
            check({tag, "_bit"}, bitOut, bits[i]);
        end
    endtask

    // done arrives 4 cycles after the last strobe.
    task automatic end_check(input string tag);
        for (int k = 0; k < 3; k++) begin
            tick();
            check({tag, "_pre_done"}, done, 0);
            check({tag, "_pre_busy"}, busy, 1);
        end
        tick();
        check({tag, "_done"}, done, 1);
        check({tag, "_idle_bit"}, bitOut, 0);
        check({tag, "_busy_off"}, busy, 0);
        tick();
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; loadValid = 1'b0; loadBit = 1'b0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_fill", fillCount, 0);
        check("rst_bit", bitOut, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_strobe", bitStrobe, 0);
        check("rst_ready", loadReady, 1);

        // 1: one-shot playback of 1,0,1,1
        load(1); load(0); load(1); load(1);
        check("t1_fill", fillCount, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_ready", loadReady, 0);
        play_bits(16'b1101, 4, 3, "t1");
        end_check("t1");

        // 2: fill to capacity, overflow refused, replay all 16
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t2_clear", fillCount, 0);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] pat;
            pat = 16'hA5C3;
            load(pat[i]);
        end
        check("t2_full", fillCount, 16);
        check("t2_ready", loadReady, 0);
        load(1);
        check("t2_sat", fillCount, 16);
        start = 1'b1;
        tick();
        start = 1'b0;
        play_bits(16'hA5C3, 16, 3, "t2");
        end_check("t2");

        // 3: looped 1,0 then stop with a strobe in flight
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load(1); load(0);
        loop  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        loop  = 1'b0;
        play_bits(16'b10101, 5, 3, "t3");
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t3_stop_bit", bitOut, 0);
        check("t3_stop_busy", busy, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t3_no_strobe", bitStrobe, 0);
            check("t3_no_done", done, 0);
        end

        // 4: empty start ignored; clear beats a same-cycle load
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_busy", busy, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4_no_strobe", bitStrobe, 0);
        end
        load(1);
        check("t4_fill1", fillCount, 1);
        clear     = 1'b1;
        loadValid = 1'b1;
        loadBit   = 1'b1;
        tick();
        clear     = 1'b0;
        loadValid = 1'b0;
        check("t4_clear_wins", fillCount, 0);

        // 5: reset two periods into an 8-bit playback
        for (int i = 0; i < 8; i++)
            load(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++)
            tick();
        check("t5_pre_busy", busy, 1);
        check("t5_pre_bit", bitOut, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_bit", bitOut, 0);
        check("t5_busy", busy, 0);
        check("t5_fill", fillCount, 0);
        check("t5_ready", loadReady, 1);

        // 6: load completing with start is played; loads blocked in PLAY
        load(0); load(1);
        check("t6_fill2", fillCount, 2);
        start     = 1'b1;
        loadValid = 1'b1;
        loadBit   = 1'b1;
        tick();
        start     = 1'b0;
        loadBit   = 1'b0;
        check("t6_busy", busy, 1);
        check("t6_fill3", fillCount, 3);
        tick();
        loadValid = 1'b0;
        check("t6_ready", loadReady, 0);
        check("t6_fill_hold", fillCount, 3);
        play_bits(16'b110, 3, 2, "t6");
        end_check("t6");
        check("t6_fill_end", fillCount, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
